// File: rtl/jtag_deser_pkg.sv
// Shared types and default sizing for the JTAG bitstream deserializer.
package jtag_deser_pkg;

  localparam int unsigned WORD_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FINAL = 2'd2
  } deser_state_e;

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready output register; a push that finds the entry
// occupied and not draining this cycle is dropped and flagged.
module deser_out_reg #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              ready,
  output logic [WORD_W-1:0] data,
  output logic              valid,
  output logic              xfer,
  output logic              drop
);

  assign xfer = valid & ready;
  assign drop = push & valid & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (push && !drop) begin
      data  <= push_data;
      valid <= 1'b1;
    end else if (xfer) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jtag_bitstream_deser.sv
// Assembles the TAP fifo DR scan stream into words, optionally holding back
// the final word of a scan as a modulo-2^WORD_W checksum.
module jtag_bitstream_deser
  import jtag_deser_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              tck_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              capture_dr_i,
  input  logic              shift_dr_i,
  input  logic              update_dr_i,
  input  logic              scan_in_i,
  input  logic              checksum_en_i,
  output logic              tdo_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              chk_done_o,
  output logic              chk_ok_o,
  output logic              overflow_o,
  output logic              trunc_o
);

  localparam int unsigned BCW = $clog2(WORD_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

  deser_state_e state, state_nxt;

  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] word_new;
  logic [WORD_W-1:0] pend;
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] fwd_data;
  logic [BCW-1:0]    bit_cnt;
  logic              pend_valid;
  logic              chk_mode;
  logic              start;
  logic              shift_en;
  logic              word_done;
  logic              fwd;
  logic              xfer;
  logic              drop;

  assign start     = sel_i & capture_dr_i;
  assign shift_en  = sel_i & shift_dr_i & (state == SHIFT) & ~start;
  assign word_done = shift_en & (bit_cnt == LAST_BIT);
  // shreg holds the first WORD_W-1 bits with the earliest at bit 0.
  assign word_new  = {scan_in_i, shreg};

  // In checksum mode a word is forwarded only once a newer one displaces it.
  assign fwd      = word_done & (~chk_mode | pend_valid);
  assign fwd_data = chk_mode ? pend : word_new;

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = SHIFT;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        SHIFT:   if (sel_i && update_dr_i) state_nxt = FINAL;
        FINAL:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      sum        <= '0;
      chk_mode   <= 1'b0;
      tdo_o      <= 1'b0;
      word_cnt_o <= '0;
      chk_done_o <= 1'b0;
      chk_ok_o   <= 1'b0;
      overflow_o <= 1'b0;
      trunc_o    <= 1'b0;
    end else if (start) begin
      bit_cnt    <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      sum        <= '0;
      chk_mode   <= checksum_en_i;
      word_cnt_o <= '0;
      chk_done_o <= 1'b0;
      chk_ok_o   <= 1'b0;
      overflow_o <= 1'b0;
      trunc_o    <= 1'b0;
    end else begin
      if (shift_en) begin
        tdo_o   <= scan_in_i;
        shreg   <= word_new[WORD_W-1:1];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
      if (word_done && chk_mode) begin
        pend       <= word_new;
        pend_valid <= 1'b1;
        if (pend_valid) sum <= sum + pend;
      end
      if (drop) overflow_o <= 1'b1;
      if (xfer) word_cnt_o <= word_cnt_o + CNT_W'(1);
      if (state == FINAL) begin
        if (chk_mode) begin
          chk_done_o <= 1'b1;
          chk_ok_o   <= pend_valid && (pend == sum);
        end
        if (bit_cnt != '0) begin
          trunc_o <= 1'b1;
          bit_cnt <= '0;
        end
      end
    end
  end

  deser_out_reg #(
    .WORD_W (WORD_W)
  ) u_out_reg (
    .clk       (tck_i),
    .rst_n     (rst_ni),
    .push      (fwd),
    .push_data (fwd_data),
    .ready     (out_ready_i),
    .data      (out_data_o),
    .valid     (out_valid_o),
    .xfer      (xfer),
    .drop      (drop)
  );

endmodule
